// File: rtl/alu_packet_parser.sv
// alu_packet_parser
//   Parses byte-stream packets from a UART receiver and produces response
//   bytes for a UART transmitter.
//   Packet layout: opcode, reserved, length LSB, length MSB, payload.
//   The length field is the total packet size, including the 4 header bytes.
//   Opcodes:
//     0xEC  echo  payload copied to the output stream
//     0xA0  add   payload words summed, result sent
//     0xA1  xor   payload words xor-ed, result sent
//   Malformed packets pulse frame_error_o and any remaining payload is
//   discarded.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   s_axis_*       input byte stream (tdata/tvalid/tready)
//   m_axis_*       output byte stream (tdata/tvalid/tready)
//   busy_o         high whenever the parser is not waiting for an opcode
//   frame_error_o  one-cycle pulse on a malformed packet
module alu_packet_parser #(
  parameter int DATA_WIDTH_P = 8,
  parameter int ACC_WIDTH_P  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH_P-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy_o,
  output logic                    frame_error_o
);

  localparam int NB    = ACC_WIDTH_P / DATA_WIDTH_P;  // bytes per operand word
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [DATA_WIDTH_P-1:0] OP_ECHO = DATA_WIDTH_P'(8'hEC);
  localparam logic [DATA_WIDTH_P-1:0] OP_ADD  = DATA_WIDTH_P'(8'hA0);
  localparam logic [DATA_WIDTH_P-1:0] OP_XOR  = DATA_WIDTH_P'(8'hA1);

  typedef enum logic [2:0] {
    HDR_OP, HDR_RSV, LEN_LSB, LEN_MSB, ECHO, OPERAND, SEND, DRAIN
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH_P-1:0] opcode_reg, opcode_next;
  logic [DATA_WIDTH_P-1:0] len_lsb_reg, len_lsb_next;
  logic [15:0]             cnt_reg, cnt_next;
  logic [ACC_WIDTH_P-1:0]  acc_reg, acc_next;
  logic [ACC_WIDTH_P-1:0]  word_reg, word_next;
  logic [IDX_W-1:0]        byte_idx_reg, byte_idx_next;
  logic [IDX_W:0]          send_cnt_reg, send_cnt_next;
  logic [DATA_WIDTH_P-1:0] out_data_reg, out_data_next;
  logic                    out_valid_reg, out_valid_next;
  logic                    ferr_reg, ferr_next;

  logic                    s_ready;
  logic                    s_xfer;
  logic                    m_xfer;
  logic                    slot_free;
  logic [15:0]             len_word;
  logic [15:0]             payload;
  logic                    payload_misaligned;
  logic [ACC_WIDTH_P-1:0]  word_cur;
  logic [ACC_WIDTH_P-1:0]  acc_upd;
  logic [DATA_WIDTH_P-1:0] acc_lane [NB];

  // The output register can take a new byte when it is empty or its
  // current byte is leaving this cycle.
  assign slot_free = !out_valid_reg || m_axis_tready;
  assign m_xfer    = out_valid_reg && m_axis_tready;
  assign s_xfer    = s_axis_tvalid && s_ready;

  assign len_word           = {s_axis_tdata, len_lsb_reg};
  assign payload            = len_word - 16'd4;
  assign payload_misaligned = (payload % 16'(NB)) != 16'd0;

  // Operand word with the incoming byte merged into its lane, so the word
  // completed by the last byte is usable in the same cycle.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign word_cur[gi*DATA_WIDTH_P +: DATA_WIDTH_P] =
        (byte_idx_reg == IDX_W'(gi)) ? s_axis_tdata
                                     : word_reg[gi*DATA_WIDTH_P +: DATA_WIDTH_P];
      assign acc_lane[gi] = acc_reg[gi*DATA_WIDTH_P +: DATA_WIDTH_P];
    end
  endgenerate

  assign acc_upd = (opcode_reg == OP_ADD) ? (acc_reg + word_cur) : (acc_reg ^ word_cur);

  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
      case (state_reg)
        HDR_OP, HDR_RSV, LEN_LSB, LEN_MSB, OPERAND, DRAIN: s_ready = 1'b1;
        ECHO:    s_ready = slot_free;
        default: s_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next     = state_reg;
    opcode_next    = opcode_reg;
    len_lsb_next   = len_lsb_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    word_next      = word_reg;
    byte_idx_next  = byte_idx_reg;
    send_cnt_next  = send_cnt_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg && !m_axis_tready;
    ferr_next      = 1'b0;

    case (state_reg)
      HDR_OP: begin
        if (s_xfer) begin
          opcode_next = s_axis_tdata;
          state_next  = HDR_RSV;
        end
      end
      HDR_RSV: begin
        if (s_xfer) state_next = LEN_LSB;
      end
      LEN_LSB: begin
        if (s_xfer) begin
          len_lsb_next = s_axis_tdata;
          state_next   = LEN_MSB;
        end
      end
      LEN_MSB: begin
        if (s_xfer) begin
          acc_next      = '0;
          word_next     = '0;
          byte_idx_next = '0;
          send_cnt_next = '0;
          cnt_next      = payload;
          if (len_word < 16'd4) begin
            ferr_next  = 1'b1;
            cnt_next   = '0;
            state_next = HDR_OP;
          end else if (opcode_reg == OP_ECHO) begin
            state_next = (payload == 16'd0) ? HDR_OP : ECHO;
          end else if ((opcode_reg == OP_ADD || opcode_reg == OP_XOR) &&
                       payload != 16'd0 && !payload_misaligned) begin
            state_next = OPERAND;
          end else begin
            ferr_next  = 1'b1;
            state_next = (payload == 16'd0) ? HDR_OP : DRAIN;
          end
        end
      end
      ECHO: begin
        if (s_xfer) begin
          out_data_next  = s_axis_tdata;
          out_valid_next = 1'b1;
          cnt_next       = cnt_reg - 16'd1;
          if (cnt_reg == 16'd1) state_next = HDR_OP;
        end
      end
      OPERAND: begin
        if (s_xfer) begin
          word_next     = word_cur;
          cnt_next      = cnt_reg - 16'd1;
          byte_idx_next = (byte_idx_reg == IDX_W'(NB-1)) ? '0 : byte_idx_reg + 1'b1;
          if (byte_idx_reg == IDX_W'(NB-1)) acc_next = acc_upd;
          if (cnt_reg == 16'd1) begin
            state_next = SEND;
            // Present the first result byte on entry to SEND; if an earlier
            // echo byte is still stalled, SEND loads it once the slot frees.
            if (slot_free) begin
              out_data_next  = acc_upd[DATA_WIDTH_P-1:0];
              out_valid_next = 1'b1;
              send_cnt_next  = (IDX_W+1)'(1);
            end
          end
        end
      end
      SEND: begin
        if (send_cnt_reg == (IDX_W+1)'(NB)) begin
          // Every byte has been loaded; leave once the last one transfers.
          if (m_xfer) state_next = HDR_OP;
        end else if (slot_free) begin
          out_data_next  = acc_lane[send_cnt_reg[IDX_W-1:0]];
          out_valid_next = 1'b1;
          send_cnt_next  = send_cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (s_xfer) begin
          cnt_next = cnt_reg - 16'd1;
          if (cnt_reg == 16'd1) state_next = HDR_OP;
        end
      end
      default: state_next = HDR_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HDR_OP;
      opcode_reg    <= '0;
      len_lsb_reg   <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      word_reg      <= '0;
      byte_idx_reg  <= '0;
      send_cnt_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ferr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      opcode_reg    <= opcode_next;
      len_lsb_reg   <= len_lsb_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      word_reg      <= word_next;
      byte_idx_reg  <= byte_idx_next;
      send_cnt_reg  <= send_cnt_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      ferr_reg      <= ferr_next;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign busy_o        = (state_reg != HDR_OP);
  assign frame_error_o = ferr_reg;

endmodule

// File: tb/tb_alu_packet_parser.sv
// tb_alu_packet_parser
//   Directed-vector bench for alu_packet_parser: echo, add with wrap, xor
//   under output backpressure, malformed packets and reset during SEND.
//   Prints one line per output byte transfer and a final summary line.
module tb_alu_packet_parser;

  logic       clk;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy_o;
  logic       frame_error_o;

  alu_packet_parser #(.DATA_WIDTH_P(8), .ACC_WIDTH_P(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .frame_error_o (frame_error_o)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         mode = 0;      // 0: tready high, 1: high one cycle in three, 2: manual
  int         ferr_cnt = 0;
  logic [7:0] pkt [$];
  logic [7:0] out_q [$];
  int         out_cyc_q [$];
  int         in_cyc_q [$];
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mode == 0) m_axis_tready = 1'b1;
    else if (mode == 1) m_axis_tready = ((cyc % 3) == 0);
  end

  // Handshakes are observed on the falling edge and complete on the next
  // rising edge; stalled output must keep its valid and data.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("stall_data", {24'd0, m_axis_tdata}, {24'd0, prev_data});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back(m_axis_tdata);
        out_cyc_q.push_back(cyc);
        $display("out byte %02h at cycle %0d", m_axis_tdata, cyc);
      end
      if (s_axis_tvalid && s_axis_tready) in_cyc_q.push_back(cyc);
      if (frame_error_o) ferr_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      s_axis_tdata  = pkt[i];
      s_axis_tvalid = 1'b1;
      while (!done) begin
        @(negedge clk);
        if (s_axis_tready) done = 1'b1;
        @(posedge clk);
        #1;
        t++;
        if (!done && t > 100) begin
          check("in_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int max_cyc);
    int t;
    t = 0;
    while (out_q.size() < n && t < max_cyc) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
    ferr_cnt = 0;
  endtask

  initial begin
    logic [7:0] exp_add [4];
    logic [7:0] exp_xor [4];
    exp_add = '{8'h01, 8'h00, 8'h00, 8'h00};
    exp_xor = '{8'hFF, 8'h00, 8'h00, 8'hFF};

    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_error_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_s_tready", {31'd0, s_axis_tready}, 32'd1);

    // Echo: three payload bytes, each one cycle behind its input.
    clear_q();
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_pkt();
    wait_outs(3, 20);
    check("echo_count", out_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < out_q.size() && (4 + i) < in_cyc_q.size()) begin
        check("echo_data", {24'd0, out_q[i]}, 32'h41 + i);
        check("echo_latency", out_cyc_q[i], in_cyc_q[4+i] + 1);
      end
    end
    check("echo_busy_after", {31'd0, busy_o}, 32'd0);
    check("echo_ferr", ferr_cnt, 32'd0);

    // Add: FFFFFFFF + 00000002 wraps to 00000001.
    clear_q();
    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    check("add_s_tready_send", {31'd0, s_axis_tready}, 32'd0);
    wait_outs(4, 20);
    check("add_count", out_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_q.size()) check("add_data", {24'd0, out_q[i]}, {24'd0, exp_add[i]});
    end
    if (out_cyc_q.size() > 0 && in_cyc_q.size() == 12)
      check("add_first_latency", out_cyc_q[0], in_cyc_q[11] + 1);
    check("add_ferr", ferr_cnt, 32'd0);
    check("add_busy_after", {31'd0, busy_o}, 32'd0);

    // Xor under backpressure: FF000FF0 ^ 00000F0F = FF0000FF.
    clear_q();
    mode = 1;
    pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'hF0, 8'h0F, 8'h00, 8'hFF,
            8'h0F, 8'h0F, 8'h00, 8'h00};
    send_pkt();
    check("xor_s_tready_send", {31'd0, s_axis_tready}, 32'd0);
    check("xor_m_tvalid_send", {31'd0, m_axis_tvalid}, 32'd1);
    check("xor_busy_send", {31'd0, busy_o}, 32'd1);
    wait_outs(4, 60);
    check("xor_count", out_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_q.size()) check("xor_data", {24'd0, out_q[i]}, {24'd0, exp_xor[i]});
    end
    mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Unknown opcode with payload: one error pulse, payload drained.
    clear_q();
    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    repeat (4) @(posedge clk);
    #1;
    check("unk_ferr", ferr_cnt, 32'd1);
    check("unk_no_out", out_q.size(), 32'd0);
    check("unk_busy_after", {31'd0, busy_o}, 32'd0);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    send_pkt();
    wait_outs(1, 20);
    check("post_err_count", out_q.size(), 32'd1);
    if (out_q.size() > 0) check("post_err_data", {24'd0, out_q[0]}, 32'h99);

    // Length below the header size.
    clear_q();
    pkt = '{8'hA0, 8'h00, 8'h03, 8'h00};
    send_pkt();
    repeat (4) @(posedge clk);
    #1;
    check("short_ferr", ferr_cnt, 32'd1);
    check("short_busy_after", {31'd0, busy_o}, 32'd0);
    check("short_no_out", out_q.size(), 32'd0);

    // Reset after the second result byte of 04030201 has transferred.
    clear_q();
    mode = 2;
    m_axis_tready = 1'b0;
    pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt();
    check("rstsend_m_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstsend_tvalid_drop", {31'd0, m_axis_tvalid}, 32'd0);
    check("rstsend_busy", {31'd0, busy_o}, 32'd0);
    check("rstsend_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rstsend_count", out_q.size(), 32'd2);
    if (out_q.size() > 1) begin
      check("rstsend_b0", {24'd0, out_q[0]}, 32'h01);
      check("rstsend_b1", {24'd0, out_q[1]}, 32'h02);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 0;
    m_axis_tready = 1'b1;
    clear_q();
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    send_pkt();
    wait_outs(1, 20);
    repeat (5) @(posedge clk);
    #1;
    check("after_rst_count", out_q.size(), 32'd1);
    if (out_q.size() > 0) check("after_rst_data", {24'd0, out_q[0]}, 32'h77);
    check("after_rst_ferr", ferr_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
